// File: rtl/mux2_1.sv
// Parameterizable 2:1 multiplexer with optional input and output register stages.
// Latency is IN_REG + OUT_REG cycles; every enabled register loads every cycle.
module mux2_1 #(
    parameter int WIDTH   = 1,
    parameter int IN_REG  = 0,
    parameter int OUT_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic             sel_s;
    logic [WIDTH-1:0] mux_y;

    generate
        if (IN_REG != 0) begin : g_in_reg
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic             sel_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sel_q <= 1'b0;
                end else begin
                    a_q   <= a;
                    b_q   <= b;
                    sel_q <= sel;
                end
            end

            assign a_s   = a_q;
            assign b_s   = b_q;
            assign sel_s = sel_q;
        end else begin : g_in_pass
            assign a_s   = a;
            assign b_s   = b;
            assign sel_s = sel;
        end
    endgenerate

    // The conditional operator merges a and b bitwise when sel is X/Z:
    // agreeing bits propagate, differing bits become X.
    assign mux_y = sel_s ? b_s : a_s;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] out_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_q <= '0;
                end else begin
                    out_q <= mux_y;
                end
            end

            assign out = out_q;
        end else begin : g_out_comb
            assign out = mux_y;
        end

        if (IN_REG == 0 && OUT_REG == 0) begin : g_no_clk
            logic unused_ctl;
            assign unused_ctl = clk ^ rst;
        end
    endgenerate

endmodule

// File: tb/tb_mux2_1.sv
// Directed, table-driven bench for mux2_1 across its combinational,
// output-registered, input-registered and fully pipelined configurations.
module tb_mux2_1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sel;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default config: WIDTH=1, IN_REG=0, OUT_REG=1
    logic       da, db, dsel;
    logic       dout;
    // Combinational: WIDTH=8, IN_REG=0, OUT_REG=0, clk/rst tied off
    logic [7:0] ca, cb;
    logic       csel;
    logic [7:0] cout;
    // Fully pipelined: WIDTH=8, IN_REG=1, OUT_REG=1
    logic [7:0] pa, pb;
    logic       psel;
    logic [7:0] pout;
    // Input register only: WIDTH=8, IN_REG=1, OUT_REG=0
    logic [7:0] ia, ib;
    logic       isel;
    logic [7:0] iout;
    // X-propagation: WIDTH=4, combinational
    logic [3:0] xa, xb;
    logic       xsel;
    logic [3:0] xout;

    mux2_1 u_def (.clk(clk), .rst(rst), .a(da), .b(db), .sel(dsel), .out(dout));

    mux2_1 #(.WIDTH(8), .IN_REG(0), .OUT_REG(0)) u_comb (
        .clk(1'b0), .rst(1'b0), .a(ca), .b(cb), .sel(csel), .out(cout));

    mux2_1 #(.WIDTH(8), .IN_REG(1), .OUT_REG(1)) u_pipe (
        .clk(clk), .rst(rst), .a(pa), .b(pb), .sel(psel), .out(pout));

    mux2_1 #(.WIDTH(8), .IN_REG(1), .OUT_REG(0)) u_inreg (
        .clk(clk), .rst(rst), .a(ia), .b(ib), .sel(isel), .out(iout));

    mux2_1 #(.WIDTH(4), .IN_REG(0), .OUT_REG(0)) u_x (
        .clk(1'b0), .rst(1'b0), .a(xa), .b(xb), .sel(xsel), .out(xout));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    vec_t dtab[5];
    vec_t ctab[6];

    initial begin
        // Default-config stream, one vector per cycle, result one edge later
        dtab[0] = '{a: 8'h0, b: 8'h1, sel: 1'b1, exp: 8'h1};
        dtab[1] = '{a: 8'h1, b: 8'h0, sel: 1'b1, exp: 8'h0};
        dtab[2] = '{a: 8'h1, b: 8'h0, sel: 1'b0, exp: 8'h1};
        dtab[3] = '{a: 8'h0, b: 8'h1, sel: 1'b0, exp: 8'h0};
        dtab[4] = '{a: 8'h1, b: 8'h1, sel: 1'b0, exp: 8'h1};

        ctab[0] = '{a: 8'hA5, b: 8'h3C, sel: 1'b0, exp: 8'hA5};
        ctab[1] = '{a: 8'hA5, b: 8'h3C, sel: 1'b1, exp: 8'h3C};
        ctab[2] = '{a: 8'hFF, b: 8'h00, sel: 1'b0, exp: 8'hFF};
        ctab[3] = '{a: 8'hFF, b: 8'h00, sel: 1'b1, exp: 8'h00};
        ctab[4] = '{a: 8'h80, b: 8'h01, sel: 1'b1, exp: 8'h01};
        ctab[5] = '{a: 8'h5A, b: 8'h5A, sel: 1'b0, exp: 8'h5A};

        da = 1'b1; db = 1'b1; dsel = 1'b1;
        ca = 8'h00; cb = 8'h00; csel = 1'b0;
        pa = 8'hFF; pb = 8'hEE; psel = 1'b1;
        ia = 8'hAA; ib = 8'h55; isel = 1'b1;
        xa = 4'b1100; xb = 4'b1010; xsel = 1'b0;

        // Reset held for two edges with all-ones inputs
        rst = 1'b1;
        tick();
        chk("def_rst_edge1", {7'd0, dout}, 8'h00);
        tick();
        chk("def_rst_edge2", {7'd0, dout}, 8'h00);
        chk("pipe_rst", pout, 8'h00);
        chk("inreg_rst", iout, 8'h00);
        rst = 1'b0;
        tick();
        chk("def_post_rst", {7'd0, dout}, 8'h01);
        chk("inreg_lat1", iout, 8'h55);

        // Default config table
        for (int i = 0; i < 5; i++) begin
            da = dtab[i].a[0]; db = dtab[i].b[0]; dsel = dtab[i].sel;
            tick();
            chk($sformatf("def_vec%0d", i), {7'd0, dout}, dtab[i].exp);
        end
        // Output must hold until the next edge
        da = 1'b0; db = 1'b0; dsel = 1'b0;
        #2;
        chk("def_hold", {7'd0, dout}, 8'h01);
        tick();
        chk("def_after_hold", {7'd0, dout}, 8'h00);

        // A reset pulse strictly between edges must be ignored
        da = 1'b1; dsel = 1'b0;
        tick();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        chk("def_async_pulse", {7'd0, dout}, 8'h01);

        // Combinational table; clk is irrelevant to this instance
        for (int i = 0; i < 6; i++) begin
            ca = ctab[i].a; cb = ctab[i].b; csel = ctab[i].sel;
            #1;
            chk($sformatf("comb_vec%0d", i), cout, ctab[i].exp);
        end

        // Pipelined latency: out two edges after the first vector
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pa = 8'h11; pb = 8'h22; psel = 1'b0;
        tick();
        chk("pipe_edge1", pout, 8'h00);
        pa = 8'h33; pb = 8'h44; psel = 1'b1;
        tick();
        chk("pipe_edge2", pout, 8'h11);
        tick();
        chk("pipe_edge3", pout, 8'h44);

        // Mid-stream one-edge reset on the pipelined instance
        pa = 8'h01; pb = 8'h02; psel = 1'b0;
        tick();
        pa = 8'h03; pb = 8'h04; psel = 1'b1;
        tick();
        chk("pipe_stream0", pout, 8'h01);
        pa = 8'h05; pb = 8'h06; psel = 1'b0; rst = 1'b1;
        tick();
        chk("pipe_rst_edge", pout, 8'h00);
        pa = 8'h07; pb = 8'h08; psel = 1'b1; rst = 1'b0;
        tick();
        chk("pipe_rst_next", pout, 8'h00);
        pa = 8'h09; pb = 8'h0A; psel = 1'b0;
        tick();
        chk("pipe_resume0", pout, 8'h08);
        tick();
        chk("pipe_resume1", pout, 8'h09);

        // Input-register-only instance: latency one
        ia = 8'h12; ib = 8'h34; isel = 1'b0;
        tick();
        chk("inreg_sel0", iout, 8'h12);
        isel = 1'b1;
        #1;
        chk("inreg_hold", iout, 8'h12);
        tick();
        chk("inreg_sel1", iout, 8'h34);

        // Unknown select: bits where a and b agree must still come through
        xsel = 1'bx;
        #1;
        chk_bit("x_bit3", xout[3], 1'b1);
        chk_bit("x_bit0", xout[0], 1'b0);
        xsel = 1'b1;
        #1;
        chk("x_sel1", {4'd0, xout}, 8'h0A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
